// File: rtl/io_intr_ctrl.sv
// Interrupt controller: edge-latches NUM_SRC sources, masks them and presents one winner to the CPU.
// Latency: a source rise is pending one edge later, and intr_req/intr_id are valid one edge after that.
// Backpressure: one interrupt at a time; later rises queue in pending until the CPU acks and sends eoi.
//
// Ports:
//   sys_clk, reset_n          clock, async active-low reset
//   irq_src[NUM_SRC]          source lines, rising-edge sensitive
//   mask_wr, mask_d, mask_q   mask register write strobe / data / current value (1 = enabled)
//   pending[NUM_SRC]          latched pending bits, unmasked view
//   intr_req, intr_id         request to CPU and the ID of the requested / in-service source
//   intr_ack, intr_eoi        CPU acknowledge and end-of-interrupt
//   busy                      interrupt acked, waiting for eoi
// Build option: define INTR_RR_EN for round-robin arbitration (default is fixed priority, lowest index wins).

module io_intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_d,
  output logic [NUM_SRC-1:0] mask_q,
  output logic [NUM_SRC-1:0] pending,
  output logic               intr_req,
  input  logic               intr_ack,
  output logic [ID_W-1:0]    intr_id,
  input  logic               intr_eoi,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    winner;
  logic               ack_take;

  assign rise     = irq_src & ~irq_prev;
  assign eligible = pending & mask_q;
  // Ack is only honoured while a request is outstanding.
  assign ack_take = (state == ST_REQ) && intr_ack;
  assign clr      = ack_take ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << intr_id) : '0;

`ifdef INTR_RR_EN
  logic [ID_W-1:0] last_id;

  // Scan last_id+1, last_id+2, ... wrapping; walking downwards lets the
  // nearest candidate be the final assignment.
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (eligible[(int'(last_id) + k) % NUM_SRC])
        winner = ID_W'((int'(last_id) + k) % NUM_SRC);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)
      last_id <= '0;
    else if (ack_take)
      last_id <= intr_id;
  end
`else
  // Fixed priority: lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i])
        winner = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_prev <= '0;
      pending  <= '0;
      mask_q   <= '0;
    end else begin
      irq_prev <= irq_src;
      // A rise on the bit being acked in the same cycle survives the clear.
      pending  <= (pending & ~clr) | rise;
      if (mask_wr)
        mask_q <= mask_d;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      intr_req <= 1'b0;
      intr_id  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state    <= ST_REQ;
            intr_req <= 1'b1;
            intr_id  <= winner;
          end
        end
        ST_REQ: begin
          // Request is held until ack even if its source gets masked;
          // a simultaneous eoi is ignored here.
          if (intr_ack) begin
            state    <= ST_SERVICE;
            intr_req <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (intr_eoi) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          intr_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_intr_ctrl.sv
module tb_io_intr_ctrl;

  logic       sys_clk;
  logic       reset_n;
  logic [7:0] irq_src;
  logic       mask_wr;
  logic [7:0] mask_d;
  logic [7:0] mask_q;
  logic [7:0] pending;
  logic       intr_req;
  logic       intr_ack;
  logic [2:0] intr_id;
  logic       intr_eoi;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  io_intr_ctrl #(.NUM_SRC(8), .ID_W(3)) dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .irq_src  (irq_src),
    .mask_wr  (mask_wr),
    .mask_d   (mask_d),
    .mask_q   (mask_q),
    .pending  (pending),
    .intr_req (intr_req),
    .intr_ack (intr_ack),
    .intr_id  (intr_id),
    .intr_eoi (intr_eoi),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ack_eoi();
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    intr_eoi = 1'b1; tick(); intr_eoi = 1'b0;
  endtask

  logic [2:0] exp_seq [4];
  logic [2:0] first_id, second_id;
  bit got;

  initial begin
    reset_n = 1'b0; irq_src = '0; mask_wr = 1'b0; mask_d = '0;
    intr_ack = 1'b0; intr_eoi = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(intr_req), 32'd0);
    chk("rst_mask", 32'(mask_q), 32'h00);
    chk("rst_pend", 32'(pending), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: single source, full handshake
    mask_wr = 1'b1; mask_d = 8'hFF; tick(); mask_wr = 1'b0;
    chk("t1_mask", 32'(mask_q), 32'hFF);
    irq_src = 8'h08; tick();
    chk("t1_pend", 32'(pending), 32'h08);
    chk("t1_req_early", 32'(intr_req), 32'd0);
    tick();
    chk("t1_req", 32'(intr_req), 32'd1);
    chk("t1_id", 32'(intr_id), 32'd3);
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    chk("t1_req_drop", 32'(intr_req), 32'd0);
    chk("t1_pend_clr", 32'(pending), 32'h00);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_hold", 32'(busy), 32'd1);
    intr_eoi = 1'b1; tick(); intr_eoi = 1'b0;
    chk("t1_busy_clr", 32'(busy), 32'd0);
    irq_src = 8'h00; tick();

    // 2: two simultaneous sources
`ifdef INTR_RR_EN
    first_id = 3'd5; second_id = 3'd1;  // last_id is 3 after test 1
`else
    first_id = 3'd1; second_id = 3'd5;
`endif
    irq_src = 8'h22; tick(); irq_src = 8'h00; tick();
    chk("t2_req1", 32'(intr_req), 32'd1);
    chk("t2_id1", 32'(intr_id), 32'(first_id));
    ack_eoi();
    chk("t2_gap", 32'(intr_req), 32'd0);
    tick();
    chk("t2_req2", 32'(intr_req), 32'd1);
    chk("t2_id2", 32'(intr_id), 32'(second_id));
    ack_eoi();
    chk("t2_pend", 32'(pending), 32'h00);

    // 3: masked source, then unmask
    mask_wr = 1'b1; mask_d = 8'hFE; tick(); mask_wr = 1'b0;
    irq_src = 8'h01; tick(); irq_src = 8'h00;
    chk("t3_pend", 32'(pending), 32'h01);
    tick(); tick();
    chk("t3_noreq", 32'(intr_req), 32'd0);
    mask_wr = 1'b1; mask_d = 8'hFF; tick(); mask_wr = 1'b0;
    chk("t3_req_early", 32'(intr_req), 32'd0);
    tick();
    chk("t3_req", 32'(intr_req), 32'd1);
    chk("t3_id", 32'(intr_id), 32'd0);
    ack_eoi();

    // 4: held-high level requests once
    irq_src = 8'h04; tick(); tick();
    chk("t4_req", 32'(intr_req), 32'd1);
    chk("t4_id", 32'(intr_id), 32'd2);
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    tick();
    intr_eoi = 1'b1; tick(); intr_eoi = 1'b0;
    repeat (5) tick();
    chk("t4_noreq", 32'(intr_req), 32'd0);
    chk("t4_pend", 32'(pending), 32'h00);
    irq_src = 8'h00; tick();

    // rise coinciding with ack clear of the same bit; eoi with ack is ignored
    irq_src = 8'h40; tick(); irq_src = 8'h00; tick();
    chk("sw_id", 32'(intr_id), 32'd6);
    irq_src = 8'h40; intr_ack = 1'b1; intr_eoi = 1'b1; tick();
    intr_ack = 1'b0; intr_eoi = 1'b0; irq_src = 8'h00;
    chk("sw_pend", 32'(pending), 32'h40);
    chk("sw_busy", 32'(busy), 32'd1);
    tick();
    chk("sw_busy_hold", 32'(busy), 32'd1);
    intr_eoi = 1'b1; tick(); intr_eoi = 1'b0; tick();
    chk("sw_rereq", 32'(intr_req), 32'd1);
    chk("sw_reid", 32'(intr_id), 32'd6);
    ack_eoi();

    // 5: reset while in REQ
    irq_src = 8'h10; tick(); irq_src = 8'h00; tick();
    chk("t5_req", 32'(intr_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_req", 32'(intr_req), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pend", 32'(pending), 32'h00);
    chk("t5_mask", 32'(mask_q), 32'h00);
    tick(); reset_n = 1'b1; tick();
    mask_wr = 1'b1; mask_d = 8'hFF; tick(); mask_wr = 1'b0;

    // 6: sources 0 and 1 re-rise after every service
`ifdef INTR_RR_EN
    exp_seq = '{3'd1, 3'd0, 3'd1, 3'd0};
`else
    exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
    irq_src = 8'h03; tick(); irq_src = 8'h00;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int w = 0; w < 6 && !got; w++) begin
        if (intr_req) got = 1'b1;
        else tick();
      end
      if (!got) begin
        chk("t6_timeout", 32'd0, 32'd1);
        break;
      end
      chk($sformatf("t6_id%0d", n), 32'(intr_id), 32'(exp_seq[n]));
      intr_ack = 1'b1; tick(); intr_ack = 1'b0;
      irq_src = 8'h03; tick(); irq_src = 8'h00;
      intr_eoi = 1'b1; tick(); intr_eoi = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
